// File: rtl/ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// ifu_pc_gen -- fetch-stage PC generator feeding the instruction cache.
//
// Owns the architectural fetch PC and presents it to the icache lookup port.
// Each clock edge picks the next PC in priority order:
//   trap target > branch redirect target > sequential advance > hold.
// A sequential advance only happens when the pipeline advances and the
// icache hits. The block also flags the instruction currently leaving the
// icache as wrong-path (fetch_squash) after any redirect, and counts the
// cycles spent waiting on an icache miss.
//
// Configuration macros:
//   PC_INITIAL_ADDRESS : default for RESET_PC (defaults to 32'h8000_0000).
//   IFU_BTB_EN         : when defined, adds a direct-mapped branch target
//                        buffer that steers sequential fetch to predicted
//                        taken targets, plus its update and prediction ports.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pipeline_en     : global advance enable (shared with the icache)
//   icache_valid    : icache hit for the current pc (combinational)
//   trap_valid/pc   : trap/exception redirect request and target
//   redirect_valid/pc : EX-stage mispredict redirect and target
//   upd_*           : BTB update port (IFU_BTB_EN only)
//   pred_taken      : prediction for the instruction at the icache output
//                     (IFU_BTB_EN only)
//   pc              : fetch PC to the icache
//   fetch_squash    : instruction at the icache output is wrong-path
//   miss_cycles     : saturating count of cycles spent in the miss state
// ---------------------------------------------------------------------------

`ifndef PC_INITIAL_ADDRESS
`define PC_INITIAL_ADDRESS 32'h8000_0000
`endif

module ifu_pc_gen #(
  parameter logic [31:0] RESET_PC    = `PC_INITIAL_ADDRESS,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic        icache_valid,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IFU_BTB_EN
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        pred_taken,
`endif
  output logic [31:0] pc,
  output logic        fetch_squash,
  output logic [31:0] miss_cycles
);

  // Instruction addresses are word aligned; the low two bits are dropped.
  localparam logic [31:0] ADDR_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ADDR_MASK;
  localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        squash_q;
  logic        squash_d;
  logic [31:0] miss_cnt_q;

  logic        cap_s;
  logic        redir_s;
  logic        seq_adv_s;
  logic [31:0] redir_tgt_s;
  logic [31:0] seq_pc_s;

  // The icache latches pc whenever the pipeline advances, and also while it
  // is missing so that the refill lookup keeps tracking the current pc.
  assign cap_s     = pipeline_en | ~icache_valid;
  assign redir_s   = trap_valid | redirect_valid;
  assign seq_adv_s = pipeline_en & icache_valid;

  // Redirect target selection: a trap always beats a branch redirect.
  always_comb begin
    redir_tgt_s = redirect_pc & ADDR_MASK;
    if (trap_valid) begin
      redir_tgt_s = trap_pc & ADDR_MASK;
    end else begin
      redir_tgt_s = redirect_pc & ADDR_MASK;
    end
  end

`ifdef IFU_BTB_EN
  // -------------------------------------------------------------------------
  // Direct-mapped BTB: index from pc[2 +: IDX_W], tag from the remaining
  // upper bits, payload is target[31:2] and a taken bit.
  // -------------------------------------------------------------------------
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [BTB_ENTRIES-1:0] btb_taken_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [29:0]            btb_tgt_q [BTB_ENTRIES];
  logic                   pred_q;

  logic [IDX_W-1:0]       lkp_idx_s;
  logic [TAG_W-1:0]       lkp_tag_s;
  logic [IDX_W-1:0]       upd_idx_s;
  logic [TAG_W-1:0]       upd_tag_s;
  logic                   btb_hit_s;
  logic                   btb_redir_s;
  logic                   unused_upd_bits_s;

  assign lkp_idx_s = pc_q[2 +: IDX_W];
  assign lkp_tag_s = pc_q[31 -: TAG_W];
  assign upd_idx_s = upd_pc[2 +: IDX_W];
  assign upd_tag_s = upd_pc[31 -: TAG_W];

  // Byte-offset bits of the update addresses carry no information.
  assign unused_upd_bits_s = ^{upd_pc[1:0], upd_target[1:0]};

  // Lookup reads the registered arrays, so a same-cycle update is not seen.
  assign btb_hit_s   = btb_valid_q[lkp_idx_s] && (btb_tag_q[lkp_idx_s] == lkp_tag_s);
  assign btb_redir_s = btb_hit_s && btb_taken_q[lkp_idx_s];

  // Sequential fetch follows a predicted-taken BTB hit, otherwise pc+4.
  always_comb begin
    seq_pc_s = pc_q + 32'd4;
    if (btb_redir_s) begin
      seq_pc_s = {btb_tgt_q[lkp_idx_s], 2'b00};
    end else begin
      seq_pc_s = pc_q + 32'd4;
    end
  end

  // BTB valid bits: cleared by reset, set by any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (upd_valid) begin
      btb_valid_q[upd_idx_s] <= 1'b1;
    end
  end

  // BTB payload: tag, target and direction, written on update (no reset).
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      btb_tag_q[upd_idx_s]   <= upd_tag_s;
      btb_tgt_q[upd_idx_s]   <= upd_target[31:2];
      btb_taken_q[upd_idx_s] <= upd_taken;
    end
  end

  // Prediction travels with the instruction captured by the icache; a
  // squashed instruction never reports a prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_q <= 1'b0;
    end else if (redir_s) begin
      pred_q <= 1'b0;
    end else if (cap_s) begin
      pred_q <= btb_redir_s;
    end else begin
      pred_q <= pred_q;
    end
  end

  assign pred_taken = pred_q;
`else
  logic unused_cfg_s;

  // Without a BTB the table size has no effect on the datapath.
  assign unused_cfg_s = (BTB_ENTRIES > 32'd1);

  // Sequential fetch is always the next word (wraps modulo 2^32).
  always_comb begin
    seq_pc_s = pc_q + 32'd4;
  end
`endif

  // Next-PC priority: trap/redirect, then sequential advance, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redir_s) begin
      pc_d = redir_tgt_s;
    end else if (seq_adv_s) begin
      pc_d = seq_pc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Squash is raised by a redirect and only dropped by a clean capture, so a
  // stall keeps the wrong-path marker on the instruction still at the output.
  always_comb begin
    squash_d = squash_q;
    if (redir_s) begin
      squash_d = 1'b1;
    end else if (cap_s) begin
      squash_d = 1'b0;
    end else begin
      squash_d = squash_q;
    end
  end

  // Fetch FSM with registered pc, squash flag and miss-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC_AL;
      squash_q   <= 1'b0;
      miss_cnt_q <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      squash_q <= squash_d;
      case (state_q)
        ST_RUN: begin
          miss_cnt_q <= miss_cnt_q;
          if (!redir_s && !icache_valid) begin
            state_q <= ST_MISS;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_MISS: begin
          // Counts every edge spent in MISS, including the exit edge.
          if (miss_cnt_q != CNT_MAX) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end else begin
            miss_cnt_q <= miss_cnt_q;
          end
          // A redirect abandons the outstanding miss.
          if (redir_s || icache_valid) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_MISS;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          miss_cnt_q <= miss_cnt_q;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign fetch_squash = squash_q;
  assign miss_cycles  = miss_cnt_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_ifu_pc_gen -- self-checking bench for ifu_pc_gen.
// Directed scenarios followed by randomized stimulus; every edge is checked
// against a behavioural model of the fetch rules kept in this file.
// ---------------------------------------------------------------------------
module tb_ifu_pc_gen;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int unsigned BTB_N  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_en;
  logic        icache_valid;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        fetch_squash;
  logic [31:0] miss_cycles;
`ifdef IFU_BTB_EN
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        pred_taken;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_sq;
  logic [31:0] m_miss;
  logic        m_inmiss;
`ifdef IFU_BTB_EN
  logic        m_pred;
  logic        m_bv    [BTB_N];
  logic [29:0] m_bword [BTB_N];
  logic [31:0] m_btgt  [BTB_N];
  logic        m_btk   [BTB_N];
`endif

  always #5 clk = ~clk;

  ifu_pc_gen #(
    .RESET_PC    (RST_PC),
    .BTB_ENTRIES (BTB_N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pipeline_en    (pipeline_en),
    .icache_valid   (icache_valid),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IFU_BTB_EN
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pred_taken     (pred_taken),
`endif
    .pc             (pc),
    .fetch_squash   (fetch_squash),
    .miss_cycles    (miss_cycles)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the current inputs, clock the DUT,
  // then compare all outputs 1 time unit after the edge.
  task automatic tick();
    logic        redir;
    logic        cap;
    logic [31:0] nxt;
`ifdef IFU_BTB_EN
    int unsigned slot;
    logic        hit_taken;
`endif
    redir = trap_valid | redirect_valid;
    cap   = pipeline_en | ~icache_valid;
    if (rst) begin
      m_pc     = RST_PC;
      m_sq     = 1'b0;
      m_miss   = 32'd0;
      m_inmiss = 1'b0;
`ifdef IFU_BTB_EN
      m_pred = 1'b0;
      for (int i = 0; i < int'(BTB_N); i++) m_bv[i] = 1'b0;
`endif
    end else begin
      if (m_inmiss && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
      m_inmiss = !redir && !icache_valid;
      nxt = m_pc + 32'd4;
`ifdef IFU_BTB_EN
      slot = (m_pc >> 2) % BTB_N;
      hit_taken = m_bv[slot] && (m_bword[slot] == m_pc[31:2]) && m_btk[slot];
      if (hit_taken) nxt = m_btgt[slot] & ~32'd3;
      if (redir) m_pred = 1'b0;
      else if (cap) m_pred = hit_taken;
      if (upd_valid) begin
        slot = (upd_pc >> 2) % BTB_N;
        m_bv[slot]    = 1'b1;
        m_bword[slot] = upd_pc[31:2];
        m_btgt[slot]  = upd_target;
        m_btk[slot]   = upd_taken;
      end
`endif
      if (trap_valid) m_pc = trap_pc & ~32'd3;
      else if (redirect_valid) m_pc = redirect_pc & ~32'd3;
      else if (pipeline_en && icache_valid) m_pc = nxt;
      if (redir) m_sq = 1'b1;
      else if (cap) m_sq = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("pc", pc, m_pc);
    check_val("squash", {31'd0, fetch_squash}, {31'd0, m_sq});
    check_val("miss_cycles", miss_cycles, m_miss);
`ifdef IFU_BTB_EN
    check_val("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred});
`endif
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 3) == 0) begin
      t = $urandom();
    end else begin
      t = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
    end
    return t;
  endfunction

  initial begin
    rst            = 1'b1;
    pipeline_en    = 1'b0;
    icache_valid   = 1'b1;
    trap_valid     = 1'b0;
    trap_pc        = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
`ifdef IFU_BTB_EN
    upd_valid  = 1'b0;
    upd_pc     = 32'd0;
    upd_target = 32'd0;
    upd_taken  = 1'b0;
`endif
    #2;
    tick();
    tick();
    check_val("rst_pc", pc, RST_PC);
    check_val("rst_squash", {31'd0, fetch_squash}, 32'd0);
    check_val("rst_miss", miss_cycles, 32'd0);

    // Sequential fetch
    rst          = 1'b0;
    pipeline_en  = 1'b1;
    icache_valid = 1'b1;
    tick(); check_val("seq_p4", pc, 32'h8000_0004);
    tick(); check_val("seq_p8", pc, 32'h8000_0008);
    tick(); check_val("seq_p12", pc, 32'h8000_000C);
    check_val("seq_squash", {31'd0, fetch_squash}, 32'd0);
    tick(); check_val("seq_p16", pc, 32'h8000_0010);

    // Five-cycle miss at 0x8000_0010
    icache_valid = 1'b0;
    repeat (5) tick();
    check_val("miss_hold", pc, 32'h8000_0010);
    icache_valid = 1'b1;
    tick();
    check_val("miss_resume_pc", pc, 32'h8000_0014);
    check_val("miss_count5", miss_cycles, 32'd5);

    // Trap and redirect together: trap wins; squash one cycle
    trap_valid = 1'b1; trap_pc = 32'h0000_0100;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    check_val("trap_wins", pc, 32'h0000_0100);
    check_val("trap_squash", {31'd0, fetch_squash}, 32'd1);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    tick();
    check_val("trap_sq_clear", {31'd0, fetch_squash}, 32'd0);
    check_val("trap_next", pc, 32'h0000_0104);

    // Same again followed by a two-cycle stall: squash held three cycles
    trap_valid = 1'b1; redirect_valid = 1'b1;
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b0; pipeline_en = 1'b0;
    tick(); check_val("stall_sq1", {31'd0, fetch_squash}, 32'd1);
    tick(); check_val("stall_sq2", {31'd0, fetch_squash}, 32'd1);
    check_val("stall_pc", pc, 32'h0000_0100);
    pipeline_en = 1'b1;
    tick(); check_val("stall_sq_clear", {31'd0, fetch_squash}, 32'd0);

    // Misaligned redirect near the top of memory, then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); check_val("align_tgt", pc, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick(); check_val("wrap_zero", pc, 32'h0000_0000);

`ifdef IFU_BTB_EN
    // BTB-predicted taken branch
    upd_valid = 1'b1; upd_pc = 32'h8000_0020; upd_target = 32'h8000_0400; upd_taken = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0018;
    tick();
    upd_valid = 1'b0; redirect_valid = 1'b0;
    tick();
    tick(); check_val("btb_at_branch", pc, 32'h8000_0020);
    tick(); check_val("btb_target", pc, 32'h8000_0400);
    check_val("btb_pred", {31'd0, pred_taken}, 32'd1);
`endif

    // Reset during a miss with a redirect pending
    icache_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    check_val("rstmiss_pc", pc, RST_PC);
    check_val("rstmiss_cnt", miss_cycles, 32'd0);
    check_val("rstmiss_sq", {31'd0, fetch_squash}, 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    tick(); check_val("rstmiss_run", miss_cycles, 32'd0);
    tick(); check_val("rstmiss_count1", miss_cycles, 32'd1);
    icache_valid = 1'b1;
    tick();

    // Randomized phase
    for (int i = 0; i < 800; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      pipeline_en    = ($urandom_range(0, 3) != 0);
      icache_valid   = ($urandom_range(0, 3) != 0);
      trap_valid     = ($urandom_range(0, 15) == 0);
      trap_pc        = rnd_tgt();
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = rnd_tgt();
`ifdef IFU_BTB_EN
      upd_valid  = ($urandom_range(0, 3) == 0);
      upd_pc     = rnd_tgt();
      upd_target = rnd_tgt();
      upd_taken  = ($urandom_range(0, 2) != 0);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
